// File: rtl/stat_update_scheduler.sv
// Pet stat bank plus its update scheduler: a ms prescaler, three per-need
// period timers and a feed request raise pending flags, and a round-robin
// arbiter applies one +/-1 update per clock to the shared stat bank.
// upd_valid/upd_sel/upd_sat form a one-cycle notification with no back-pressure:
// upd_valid is high for exactly the cycle in which the new stat value is first visible.
module stat_update_scheduler #(
    parameter int CLK_PER_MS = 50000,
    parameter int ENER_MS    = 40000,
    parameter int FEED_MS    = 10000,
    parameter int ENT_MS     = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_sleep,
    input  logic       mode_play,
    input  logic       mode_dead,
    input  logic       feed_pulse,
    output logic [2:0] energy,
    output logic [2:0] hunger,
    output logic [2:0] entertainment,
    output logic       ms_tick,
    output logic       upd_valid,
    output logic [1:0] upd_sel,
    output logic       upd_sat,
    output logic       evt_drop
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int EW = (ENER_MS > 1) ? $clog2(ENER_MS) : 1;
    localparam int FW = (FEED_MS > 1) ? $clog2(FEED_MS) : 1;
    localparam int TW = (ENT_MS > 1) ? $clog2(ENT_MS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [EW-1:0] ENER_LAST  = EW'(ENER_MS - 1);
    localparam logic [FW-1:0] FEED_LAST  = FW'(FEED_MS - 1);
    localparam logic [TW-1:0] ENT_LAST   = TW'(ENT_MS - 1);
    localparam logic [2:0]    STAT_MAX   = 3'd5;

    logic [PW-1:0] presc_q;
    logic [EW-1:0] ener_cnt_q;
    logic [FW-1:0] feed_cnt_q;
    logic [TW-1:0] ent_cnt_q;
    logic [3:0]    pending_q, pending_d;
    logic [1:0]    rr_q;
    logic [2:0]    energy_q, hunger_q, ent_q;
    logic          upd_valid_q, upd_sat_q, evt_drop_q;
    logic [1:0]    upd_sel_q;

    logic          tick, run;
    logic [3:0]    evt, gnt_onehot;
    logic          gnt_vld;
    logic [1:0]    gnt_idx, scan_idx;
    logic [2:0]    stat_cur, stat_d;
    logic          stat_inc, stat_sat, drop_d;

    assign tick = (presc_q == PRESC_LAST);
    assign run  = ~mode_dead;

    // ms prescaler: free-running, keeps counting even while dead
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PW'(1);
    end

    // Per-need period counters: advance on ms ticks only, frozen while dead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ener_cnt_q <= '0;
            feed_cnt_q <= '0;
            ent_cnt_q  <= '0;
        end else if (tick && run) begin
            ener_cnt_q <= (ener_cnt_q == ENER_LAST) ? '0 : ener_cnt_q + EW'(1);
            feed_cnt_q <= (feed_cnt_q == FEED_LAST) ? '0 : feed_cnt_q + FW'(1);
            ent_cnt_q  <= (ent_cnt_q == ENT_LAST) ? '0 : ent_cnt_q + TW'(1);
        end
    end

    // Event sources: timer wraps and the feed request, all suppressed while dead
    always_comb begin
        evt    = 4'b0000;
        evt[0] = tick && run && (ener_cnt_q == ENER_LAST);
        evt[1] = tick && run && (feed_cnt_q == FEED_LAST);
        evt[2] = tick && run && (ent_cnt_q == ENT_LAST);
        evt[3] = feed_pulse && run;
    end

    // Round-robin arbiter: first pending source at or after rr_q, wrapping at 3
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_q + 2'(k);
            if (pending_q[scan_idx]) begin
                gnt_vld = run;
                gnt_idx = scan_idx;
            end
        end
        gnt_onehot = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    // Granted stat: direction sampled now, saturating at 0 and 5
    always_comb begin
        stat_cur = hunger_q;
        stat_inc = 1'b0;
        case (gnt_idx)
            2'd0:    begin stat_cur = energy_q; stat_inc = mode_sleep; end
            2'd1:    begin stat_cur = hunger_q; stat_inc = 1'b0;       end
            2'd2:    begin stat_cur = ent_q;    stat_inc = mode_play;  end
            default: begin stat_cur = hunger_q; stat_inc = 1'b1;       end
        endcase
        stat_sat = stat_inc ? (stat_cur == STAT_MAX) : (stat_cur == 3'd0);
        if (stat_sat)      stat_d = stat_cur;
        else if (stat_inc) stat_d = stat_cur + 3'd1;
        else               stat_d = stat_cur - 3'd1;
    end

    // Pending update: a new event beats the clear of a same-cycle grant
    always_comb begin
        pending_d = run ? ((pending_q & ~gnt_onehot) | evt) : 4'b0000;
        drop_d    = |(evt & pending_q & ~gnt_onehot);
    end

    // Pending flags, rr pointer and the registered notification pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 4'b0000;
            rr_q        <= 2'd0;
            upd_valid_q <= 1'b0;
            upd_sel_q   <= 2'd0;
            upd_sat_q   <= 1'b0;
            evt_drop_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            if (gnt_vld) rr_q <= gnt_idx + 2'd1;
            upd_valid_q <= gnt_vld;
            upd_sel_q   <= gnt_vld ? gnt_idx : 2'd0;
            upd_sat_q   <= gnt_vld && stat_sat;
            evt_drop_q  <= drop_d;
        end
    end

    // Single-write stat bank; feed and hunger-decay share the hunger register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            energy_q <= STAT_MAX;
            hunger_q <= STAT_MAX;
            ent_q    <= STAT_MAX;
        end else if (gnt_vld) begin
            case (gnt_idx)
                2'd0:    energy_q <= stat_d;
                2'd2:    ent_q    <= stat_d;
                default: hunger_q <= stat_d;
            endcase
        end
    end

    assign energy        = energy_q;
    assign hunger        = hunger_q;
    assign entertainment = ent_q;
    assign ms_tick       = tick;
    assign upd_valid     = upd_valid_q;
    assign upd_sel       = upd_sel_q;
    assign upd_sat       = upd_sat_q;
    assign evt_drop      = evt_drop_q;

endmodule
